// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Display raster timing generator. Divides the system clock
//                into a pixel strobe and produces screen position, sync,
//                data-enable and line/frame start strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int   CORDW   = 10,
  parameter int   CLK_DIV = 2,
  parameter int   H_RES   = 640,
  parameter int   H_FP    = 16,
  parameter int   H_SYNC  = 96,
  parameter int   H_BP    = 48,
  parameter int   V_RES   = 480,
  parameter int   V_FP    = 10,
  parameter int   V_SYNC  = 2,
  parameter int   V_BP    = 33,
  parameter logic H_POL   = 1'b0,
  parameter logic V_POL   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart,
  output logic             pix_en,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             line,
  output logic             frame
);

  // Raster geometry, all expressed in the coordinate width.
  localparam int c_H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int c_V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

  localparam logic [CORDW-1:0] c_H_LAST     = CORDW'(c_H_TOTAL - 1);
  localparam logic [CORDW-1:0] c_V_LAST     = CORDW'(c_V_TOTAL - 1);
  localparam logic [CORDW-1:0] c_H_ACT      = CORDW'(H_RES);
  localparam logic [CORDW-1:0] c_V_ACT      = CORDW'(V_RES);
  localparam logic [CORDW-1:0] c_HS_START   = CORDW'(H_RES + H_FP);
  localparam logic [CORDW-1:0] c_HS_END     = CORDW'(H_RES + H_FP + H_SYNC);
  localparam logic [CORDW-1:0] c_VS_START   = CORDW'(V_RES + V_FP);
  localparam logic [CORDW-1:0] c_VS_END     = CORDW'(V_RES + V_FP + V_SYNC);
  localparam logic [CORDW-1:0] c_COORD_ONE  = CORDW'(1);

  logic [CORDW-1:0] sx_q, sx_d;
  logic [CORDW-1:0] sy_q, sy_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             de_q, de_d;

  // --------------------------------------------------------------------------
  // Pixel-rate divider. With a divide of one there is no counter at all and
  // the strobe is tied high, so it also reads 1 while reset is asserted.
  // --------------------------------------------------------------------------
  generate
    if (CLK_DIV == 1) begin : g_div_bypass
      assign pix_en = 1'b1;
    end else begin : g_div_cnt
      localparam int                 c_DIV_W    = $clog2(CLK_DIV);
      localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
      localparam logic [c_DIV_W-1:0] c_DIV_ONE  = c_DIV_W'(1);

      logic [c_DIV_W-1:0] div_cnt_q, div_cnt_d;

      // Next divider count: wrap at the last phase, restart realigns to phase 0.
      always_comb begin
        div_cnt_d = div_cnt_q + c_DIV_ONE;
        if (restart || (div_cnt_q == c_DIV_LAST)) begin
          div_cnt_d = '0;
        end
      end

      // Divider phase register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          div_cnt_q <= '0;
        end else begin
          div_cnt_q <= div_cnt_d;
        end
      end

      assign pix_en = (div_cnt_q == c_DIV_LAST);
    end
  endgenerate

  // Next raster position. Restart parks the raster on the last pixel of the
  // last line, so the first advance after it lands on (0,0) exactly as after
  // reset release. Restart takes priority over any pending advance or wrap.
  always_comb begin
    sx_d = sx_q;
    sy_d = sy_q;
    if (restart) begin
      sx_d = c_H_LAST;
      sy_d = c_V_LAST;
    end else if (pix_en) begin
      if (sx_q == c_H_LAST) begin
        sx_d = '0;
        if (sy_q == c_V_LAST) begin
          sy_d = '0;
        end else begin
          sy_d = sy_q + c_COORD_ONE;
        end
      end else begin
        sx_d = sx_q + c_COORD_ONE;
      end
    end
  end

  // Sync and data-enable decoded from the next position, so the registered
  // versions always describe the position presented alongside them.
  always_comb begin
    hsync_d = ~H_POL;
    vsync_d = ~V_POL;
    de_d    = 1'b0;
    if ((sx_d >= c_HS_START) && (sx_d < c_HS_END)) begin
      hsync_d = H_POL;
    end
    if ((sy_d >= c_VS_START) && (sy_d < c_VS_END)) begin
      vsync_d = V_POL;
    end
    if ((sx_d < c_H_ACT) && (sy_d < c_V_ACT)) begin
      de_d = 1'b1;
    end
  end

  // Raster state register; reset presents the last pixel of the frame with
  // sync inactive and the active area closed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sx_q    <= c_H_LAST;
      sy_q    <= c_V_LAST;
      hsync_q <= ~H_POL;
      vsync_q <= ~V_POL;
      de_q    <= 1'b0;
    end else begin
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
    end
  end

  // Line and frame strobes are qualified by the pixel strobe so each lasts
  // exactly one clk even though the position is held for CLK_DIV cycles.
  always_comb begin
    line  = pix_en && (sx_q == '0);
    frame = pix_en && (sx_q == '0) && (sy_q == '0);
  end

  assign sx    = sx_q;
  assign sy    = sy_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign de    = de_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Self-checking bench for vga_timing_gen. Three instances
//                (default 640x480, a tiny raster for whole-frame runs, and a
//                divide-by-one positive-polarity build) are compared every
//                cycle against an arithmetic model of the raster.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

  typedef struct {
    int d, hr, hf, hs, hb, vr, vf, vs, vb;
    bit hp, vp;
  } geom_t;

  typedef struct {
    bit pix, line, frame, de, hs, vs;
    int sx, sy;
  } outs_t;

  typedef struct {
    int    k;
    outs_t e;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic r_def = 1'b0;
  logic r_sm  = 1'b0;
  logic r_d1  = 1'b0;

  logic       d_pix, d_hs, d_vs, d_de, d_line, d_frame;
  logic [9:0] d_sx, d_sy;
  logic       s_pix, s_hs, s_vs, s_de, s_line, s_frame;
  logic [5:0] s_sx, s_sy;
  logic       o_pix, o_hs, o_vs, o_de, o_line, o_frame;
  logic [9:0] o_sx, o_sy;

  int     checks = 0;
  int     errors = 0;
  int     cyc    = 0;
  longint k_def  = 0;
  longint k_sm   = 0;
  longint k_d1   = 0;

  geom_t g_def, g_sm, g_d1;

  // Spacing trackers: a "disturbed" interval (reset or restart) is not checked.
  bit def_dist = 1'b1;
  bit sm_dist  = 1'b1;
  bit d1_dist  = 1'b1;
  int def_last = -1;
  int sm_last  = -1;
  int d1_last  = -1;
  int def_hs_cnt = 0;

  always #5 clk = ~clk;

  vga_timing_gen u_def (
    .clk(clk), .rst_n(rst_n), .restart(r_def), .pix_en(d_pix), .sx(d_sx), .sy(d_sy),
    .hsync(d_hs), .vsync(d_vs), .de(d_de), .line(d_line), .frame(d_frame)
  );

  vga_timing_gen #(
    .CORDW(6), .CLK_DIV(3), .H_RES(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_RES(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .H_POL(1'b1), .V_POL(1'b0)
  ) u_sm (
    .clk(clk), .rst_n(rst_n), .restart(r_sm), .pix_en(s_pix), .sx(s_sx), .sy(s_sy),
    .hsync(s_hs), .vsync(s_vs), .de(s_de), .line(s_line), .frame(s_frame)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_POL(1'b1), .V_POL(1'b1)
  ) u_d1 (
    .clk(clk), .rst_n(rst_n), .restart(r_d1), .pix_en(o_pix), .sx(o_sx), .sy(o_sy),
    .hsync(o_hs), .vsync(o_vs), .de(o_de), .line(o_line), .frame(o_frame)
  );

  // Reference: k = clk edges since reset/restart. Pixel advances = floor(k/d),
  // position index starts at the last pixel of the frame.
  function automatic outs_t model(input geom_t g, input longint k);
    outs_t  o;
    longint ht, vt, tot, n, p;
    ht  = g.hr + g.hf + g.hs + g.hb;
    vt  = g.vr + g.vf + g.vs + g.vb;
    tot = ht * vt;
    n   = k / g.d;
    p   = (n + tot - 1) % tot;
    o.pix   = ((k % g.d) == (g.d - 1));
    o.sx    = int'(p % ht);
    o.sy    = int'(p / ht);
    o.hs    = (o.sx >= g.hr + g.hf && o.sx < g.hr + g.hf + g.hs) ? g.hp : !g.hp;
    o.vs    = (o.sy >= g.vr + g.vf && o.sy < g.vr + g.vf + g.vs) ? g.vp : !g.vp;
    o.de    = (o.sx < g.hr) && (o.sy < g.vr);
    o.line  = o.pix && (o.sx == 0);
    o.frame = o.line && (o.sy == 0);
    return o;
  endfunction

  function automatic outs_t act_def();
    outs_t o;
    o.pix = d_pix; o.line = d_line; o.frame = d_frame; o.de = d_de;
    o.hs = d_hs; o.vs = d_vs; o.sx = int'(d_sx); o.sy = int'(d_sy);
    return o;
  endfunction

  function automatic outs_t act_sm();
    outs_t o;
    o.pix = s_pix; o.line = s_line; o.frame = s_frame; o.de = s_de;
    o.hs = s_hs; o.vs = s_vs; o.sx = int'(s_sx); o.sy = int'(s_sy);
    return o;
  endfunction

  function automatic outs_t act_d1();
    outs_t o;
    o.pix = o_pix; o.line = o_line; o.frame = o_frame; o.de = o_de;
    o.hs = o_hs; o.vs = o_vs; o.sx = int'(o_sx); o.sy = int'(o_sy);
    return o;
  endfunction

  function automatic vec_t mkv(input int k, input bit pix, input bit ln, input bit fr,
                               input bit de, input bit hs, input bit vs,
                               input int sx, input int sy);
    vec_t v;
    v.k = k;
    v.e.pix = pix; v.e.line = ln; v.e.frame = fr; v.e.de = de;
    v.e.hs = hs; v.e.vs = vs; v.e.sx = sx; v.e.sy = sy;
    return v;
  endfunction

  task automatic cmp(input string name, input outs_t a, input outs_t e);
    checks++;
    if (a.pix !== e.pix || a.line !== e.line || a.frame !== e.frame || a.de !== e.de ||
        a.hs !== e.hs || a.vs !== e.vs || a.sx != e.sx || a.sy != e.sy) begin
      errors++;
      $display("FAIL %s cyc=%0d got pix=%0b line=%0b frame=%0b de=%0b hs=%0b vs=%0b sx=%0d sy=%0d want pix=%0b line=%0b frame=%0b de=%0b hs=%0b vs=%0b sx=%0d sy=%0d",
               name, cyc, a.pix, a.line, a.frame, a.de, a.hs, a.vs, a.sx, a.sy,
               e.pix, e.line, e.frame, e.de, e.hs, e.vs, e.sx, e.sy);
    end
  endtask

  task automatic cmp_int(input string name, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s cyc=%0d got %0d want %0d", name, cyc, a, e);
    end
  endtask

  // One clk: advance the model on the edge, then compare on the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (!rst_n) begin
      k_def = 0; k_sm = 0; k_d1 = 0;
      def_dist = 1'b1; sm_dist = 1'b1; d1_dist = 1'b1;
    end else begin
      if (r_def) begin k_def = 0; def_dist = 1'b1; end else k_def++;
      if (r_sm)  begin k_sm  = 0; sm_dist  = 1'b1; end else k_sm++;
      if (r_d1)  begin k_d1  = 0; d1_dist  = 1'b1; end else k_d1++;
    end
    @(negedge clk);
    cyc++;
    cmp("def_model", act_def(), model(g_def, k_def));
    cmp("small_model", act_sm(), model(g_sm, k_sm));
    cmp("div1_model", act_d1(), model(g_d1, k_d1));
    if (d_pix && !d_hs) def_hs_cnt++;
    if (d_line) begin
      if (!def_dist && def_last >= 0) begin
        cmp_int("def_line_period", cyc - def_last, 1600);
        cmp_int("def_hsync_pixels", def_hs_cnt, 96);
      end
      def_last = cyc; def_dist = 1'b0; def_hs_cnt = 0;
    end
    if (s_frame) begin
      if (!sm_dist && sm_last >= 0) cmp_int("small_frame_period", cyc - sm_last, 360);
      sm_last = cyc; sm_dist = 1'b0;
    end
    if (o_line) begin
      if (!d1_dist && d1_last >= 0) cmp_int("div1_line_period", cyc - d1_last, 800);
      d1_last = cyc; d1_dist = 1'b0;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog cyc=%0d got timeout want completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[12];
    outs_t e;
    int idx;
    int n;

    g_def = '{2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    g_sm  = '{3, 8, 2, 3, 2, 4, 1, 2, 1, 1'b1, 1'b0};
    g_d1  = '{1, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1, 1'b1};

    //            k     pix ln fr de hs vs  sx   sy
    tbl[0]  = mkv(0,    0,  0, 0, 0, 1, 1, 799, 524);
    tbl[1]  = mkv(1,    1,  0, 0, 0, 1, 1, 799, 524);
    tbl[2]  = mkv(2,    0,  0, 0, 1, 1, 1,   0,   0);
    tbl[3]  = mkv(3,    1,  1, 1, 1, 1, 1,   0,   0);
    tbl[4]  = mkv(4,    0,  0, 0, 1, 1, 1,   1,   0);
    tbl[5]  = mkv(1281, 1,  0, 0, 1, 1, 1, 639,   0);
    tbl[6]  = mkv(1282, 0,  0, 0, 0, 1, 1, 640,   0);
    tbl[7]  = mkv(1314, 0,  0, 0, 0, 0, 1, 656,   0);
    tbl[8]  = mkv(1504, 0,  0, 0, 0, 0, 1, 751,   0);
    tbl[9]  = mkv(1506, 0,  0, 0, 0, 1, 1, 752,   0);
    tbl[10] = mkv(1601, 1,  0, 0, 0, 1, 1, 799,   0);
    tbl[11] = mkv(1603, 1,  1, 0, 1, 1, 1,   0,   1);

    // Reset held: every instance shows its reset state.
    repeat (3) cycle();

    // Release and walk the table against the default instance.
    rst_n = 1'b1;
    idx = 0;
    for (int i = 0; i < 3300; i++) begin
      if (idx < 12 && tbl[idx].k == int'(k_def)) begin
        cmp($sformatf("tbl_k%0d", tbl[idx].k), act_def(), tbl[idx].e);
        idx++;
      end
      cycle();
    end
    cmp_int("tbl_entries_applied", idx, 12);

    // One-cycle restart at sx=400: next state is the reset position.
    n = 0;
    while (d_sx != 10'd400 && n < 4000) begin cycle(); n++; end
    cmp_int("reach_sx400", (d_sx == 10'd400) ? 1 : 0, 1);
    r_def = 1'b1;
    cycle();
    r_def = 1'b0;
    cmp("restart_state", act_def(), mkv(0, 0, 0, 0, 0, 1, 1, 799, 524).e);
    n = 0;
    do begin cycle(); n++; end while (!d_frame && n < 10);
    cmp_int("restart_to_frame_edges", n, 3);

    // Randomized restarts on all instances.
    for (int i = 0; i < 20000; i++) begin
      r_def = ($urandom_range(0, 2999) == 0);
      r_sm  = ($urandom_range(0, 399) == 0);
      r_d1  = ($urandom_range(0, 1999) == 0);
      cycle();
    end
    r_def = 1'b0; r_sm = 1'b0; r_d1 = 1'b0;

    // Asynchronous reset mid-line while hsync is active.
    n = 0;
    while (!(d_sx == 10'd700 && !d_pix) && n < 4000) begin cycle(); n++; end
    cmp_int("reach_sx700", (d_sx == 10'd700) ? 1 : 0, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    e = model(g_def, 0);
    cmp("async_rst_def", act_def(), e);
    cmp("async_rst_div1", act_d1(), model(g_d1, 0));
    repeat (3) cycle();
    rst_n = 1'b1;
    repeat (50) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
